// File: rtl/thumb_fetch_align.sv
// thumb_fetch_align
//   Halfword alignment buffer in front of the Thumb-2 pattern matcher.
//   Word-aligned 32-bit fetch words are split into halfwords and kept in a
//   small circular queue. The head of the queue is presented as one
//   complete 16- or 32-bit instruction per handshake, together with its PC.
//   A flush empties the queue and redirects to a halfword-aligned target.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   word_valid/ready/data fetch word input; data[15:0] is the lower address
//   flush, flush_pc       discard everything, restart at flush_pc (bit 0 ignored)
//   inst_valid/ready      instruction handshake toward the decoder
//   inst                  16-bit: {hw0,16'h0000}; 32-bit: {hw0,hw1}
//   inst_is32, inst_pc    encoding size and address of hw0
//   cnt16, cnt32          consumed-instruction counters
//
// Configuration
//   THUMB_FETCH_ALIGN_STATS_EN  defined: cnt16/cnt32 count consumed
//                               instructions; undefined: tied to zero.

module thumb_fetch_align #(
    parameter int unsigned HW_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [31:0] word_data,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        inst_is32,
    output logic [31:0] inst_pc,
    output logic [31:0] cnt16,
    output logic [31:0] cnt32
);

    localparam int unsigned PTR_W = $clog2(HW_DEPTH);
    localparam int unsigned CNT_W = $clog2(HW_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] ACCEPT_MAX = CNT_W'(HW_DEPTH - 2);
    localparam logic [PTR_W:0]   PTR_WRAP   = (PTR_W + 1)'(HW_DEPTH);
    localparam logic [31:0]      RESET_HEAD = {RESET_PC[31:1], 1'b0};

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       n);
        logic [PTR_W:0] sum;
        sum = {1'b0, ptr} + {{(PTR_W - 1){1'b0}}, n};
        if (sum >= PTR_WRAP) begin
            sum = sum - PTR_WRAP;
        end
        return sum[PTR_W-1:0];
    endfunction

    logic [15:0]      mem_q [HW_DEPTH];
    logic [15:0]      mem_d [HW_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic             drop_lo_q, drop_lo_d;

    logic [15:0] head_hw0;
    logic [15:0] head_hw1;
    logic        head_is32;
    logic        accept;
    logic        pop;
    logic [1:0]  n_push;
    logic [1:0]  n_pop;

    logic unused_flush_pc0;
    assign unused_flush_pc0 = flush_pc[0];

    assign head_hw0  = mem_q[rd_ptr_q];
    assign head_hw1  = mem_q[ptr_add(rd_ptr_q, 2'd1)];
    // 32-bit encodings: hw0[15:11] is 11101, 11110 or 11111.
    assign head_is32 = (head_hw0[15:13] == 3'b111) && (head_hw0[12:11] != 2'b00);

    // Handshakes. Acceptance looks only at the registered count, so a word
    // is taken only when both of its halfwords are guaranteed a free slot.
    always_comb begin
        word_ready = !flush && (count_q <= ACCEPT_MAX);
        accept     = word_valid && word_ready;
        inst_valid = !flush && (((count_q >= CNT_ONE) && !head_is32) ||
                                ((count_q >= CNT_TWO) &&  head_is32));
        pop        = inst_valid && inst_ready;
        n_push     = accept ? (drop_lo_q ? 2'd1 : 2'd2) : 2'd0;
        n_pop      = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    end

    // Head presentation. The second halfword of a partially buffered 32-bit
    // instruction reads as zero rather than exposing a stale queue slot.
    always_comb begin
        inst      = 32'h0;
        inst_is32 = 1'b0;
        inst_pc   = head_pc_q;
        if (count_q != '0) begin
            inst_is32 = head_is32;
            if (head_is32) begin
                inst = {head_hw0, (count_q >= CNT_TWO) ? head_hw1 : 16'h0000};
            end else begin
                inst = {head_hw0, 16'h0000};
            end
        end
    end

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_pc_d = head_pc_q;
        drop_lo_d = drop_lo_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            head_pc_d = {flush_pc[31:1], 1'b0};
            // A target at addr+2 means the low halfword of the next word
            // belongs to the previous path and must be skipped.
            drop_lo_d = flush_pc[1];
        end else begin
            if (accept) begin
                if (drop_lo_q) begin
                    mem_d[wr_ptr_q] = word_data[31:16];
                    drop_lo_d       = 1'b0;
                end else begin
                    mem_d[wr_ptr_q]                = word_data[15:0];
                    mem_d[ptr_add(wr_ptr_q, 2'd1)] = word_data[31:16];
                end
                wr_ptr_d = ptr_add(wr_ptr_q, n_push);
            end
            if (pop) begin
                rd_ptr_d  = ptr_add(rd_ptr_q, n_pop);
                head_pc_d = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
            end
            count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(HW_DEPTH); i++) begin
                mem_q[i] <= 16'h0000;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_HEAD;
            drop_lo_q <= RESET_PC[1];
        end else begin
            mem_q     <= mem_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            drop_lo_q <= drop_lo_d;
        end
    end

`ifdef THUMB_FETCH_ALIGN_STATS_EN
    logic [31:0] cnt16_q, cnt16_d;
    logic [31:0] cnt32_q, cnt32_d;

    always_comb begin
        cnt16_d = cnt16_q;
        cnt32_d = cnt32_q;
        if (pop) begin
            if (head_is32) begin
                cnt32_d = cnt32_q + 32'd1;
            end else begin
                cnt16_d = cnt16_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt16_q <= 32'h0;
            cnt32_q <= 32'h0;
        end else begin
            cnt16_q <= cnt16_d;
            cnt32_q <= cnt32_d;
        end
    end

    assign cnt16 = cnt16_q;
    assign cnt32 = cnt32_q;
`else
    assign cnt16 = 32'h0;
    assign cnt32 = 32'h0;
`endif

endmodule

// File: tb/tb_thumb_fetch_align.sv
// Testbench for thumb_fetch_align: directed scenarios plus a randomized run
// checked against a halfword-queue reference model.

module tb_thumb_fetch_align;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef THUMB_FETCH_ALIGN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [31:0] word_data = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic        inst_is32;
    logic [31:0] inst_pc;
    logic [31:0] cnt16;
    logic [31:0] cnt32;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    thumb_fetch_align #(.HW_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_is32  (inst_is32),
        .inst_pc    (inst_pc),
        .cnt16      (cnt16),
        .cnt32      (cnt32)
    );

    function automatic bit ref_is32(input logic [15:0] hw);
        return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) || (hw[15:11] == 5'b11111);
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned n);
        return STATS ? 32'(n) : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        word_valid = 1'b0;
        word_data  = 32'h0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        inst_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h expected 0", inst); else n_pass++;
        n_checks++; if (inst_is32 !== 1'b0) $display("FAIL rst_is32: got %b expected 0", inst_is32); else n_pass++;
        n_checks++; if (inst_pc !== RST_PC) $display("FAIL rst_pc: got %h expected %h", inst_pc, RST_PC); else n_pass++;
        n_checks++; if (cnt16 !== 32'h0) $display("FAIL rst_cnt16: got %h expected 0", cnt16); else n_pass++;
        n_checks++; if (cnt32 !== 32'h0) $display("FAIL rst_cnt32: got %h expected 0", cnt32); else n_pass++;
        n_checks++; if (word_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", word_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single16();
        apply_reset();
        inst_ready = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h4141_1888;
        @(negedge clk);
        n_checks++; if (word_ready !== 1'b1) $display("FAIL s16_ready: got %b expected 1", word_ready); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL s16_valid0: got %b expected 0", inst_valid); else n_pass++;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL s16_valid1: got %b expected 1", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL s16_inst1: got %h expected 18880000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL s16_pc1: got %h expected 0", inst_pc); else n_pass++;
        n_checks++; if (inst_is32 !== 1'b0) $display("FAIL s16_is32: got %b expected 0", inst_is32); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst !== 32'h4141_0000) $display("FAIL s16_inst2: got %h expected 41410000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h2) $display("FAIL s16_pc2: got %h expected 2", inst_pc); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL s16_empty: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (cnt16 !== exp_cnt(2)) $display("FAIL s16_cnt16: got %h expected %h", cnt16, exp_cnt(2)); else n_pass++;
        n_checks++; if (inst_pc !== 32'h4) $display("FAIL s16_pc3: got %h expected 4", inst_pc); else n_pass++;
    endtask

    task automatic test_single32();
        apply_reset();
        inst_ready = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h0203_F101;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL s32_valid: got %b expected 1", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'hF101_0203) $display("FAIL s32_inst: got %h expected f1010203", inst); else n_pass++;
        n_checks++; if (inst_is32 !== 1'b1) $display("FAIL s32_is32: got %b expected 1", inst_is32); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL s32_pc: got %h expected 0", inst_pc); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL s32_empty: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (cnt32 !== exp_cnt(1)) $display("FAIL s32_cnt32: got %h expected %h", cnt32, exp_cnt(1)); else n_pass++;
        n_checks++; if (inst_pc !== 32'h4) $display("FAIL s32_pc_next: got %h expected 4", inst_pc); else n_pass++;
    endtask

    task automatic test_straddle();
        apply_reset();
        inst_ready = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'hF101_1888;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL str_first: got %h expected 18880000", inst); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL str_first_v: got %b expected 1", inst_valid); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (inst_valid !== 1'b0) $display("FAIL str_wait%0d: got %b expected 0", i, inst_valid); else n_pass++;
            n_checks++; if (inst_pc !== 32'h2) $display("FAIL str_wait_pc%0d: got %h expected 2", i, inst_pc); else n_pass++;
            tick();
        end
        word_valid = 1'b1;
        word_data  = 32'h4141_0203;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL str_arrive: got %b expected 0", inst_valid); else n_pass++;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'hF101_0203) $display("FAIL str_inst32: got %h expected f1010203", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h2) $display("FAIL str_pc32: got %h expected 2", inst_pc); else n_pass++;
        n_checks++; if (inst_is32 !== 1'b1) $display("FAIL str_is32: got %b expected 1", inst_is32); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst !== 32'h4141_0000) $display("FAIL str_last: got %h expected 41410000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h6) $display("FAIL str_last_pc: got %h expected 6", inst_pc); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        word_valid = 1'b1;
        word_data  = 32'h4141_1888;
        tick();
        flush      = 1'b1;
        flush_pc   = 32'h0000_0102;
        word_data  = 32'hDEAD_BEEF;
        inst_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (word_ready !== 1'b0) $display("FAIL fl_ready: got %b expected 0", word_ready); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL fl_valid: got %b expected 0", inst_valid); else n_pass++;
        tick();
        flush     = 1'b0;
        word_data = 32'h1888_4141;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL fl_empty: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (inst_pc !== 32'h102) $display("FAIL fl_pc: got %h expected 102", inst_pc); else n_pass++;
        n_checks++; if (cnt16 !== 32'h0) $display("FAIL fl_nocount: got %h expected 0", cnt16); else n_pass++;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL fl_inst: got %h expected 18880000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h102) $display("FAIL fl_inst_pc: got %h expected 102", inst_pc); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL fl_drained: got %b expected 0", inst_valid); else n_pass++;
        // Second flush replaces a still-pending drop of the low halfword.
        flush    = 1'b1;
        flush_pc = 32'h0000_0102;
        tick();
        flush_pc = 32'h0000_0200;
        tick();
        flush      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'h1888_4141;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'h4141_0000) $display("FAIL fl2_inst: got %h expected 41410000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h200) $display("FAIL fl2_pc: got %h expected 200", inst_pc); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL fl2_inst2: got %h expected 18880000", inst); else n_pass++;
        tick();
        // Flush discards a half-buffered 32-bit instruction.
        flush    = 1'b1;
        flush_pc = 32'h0000_0102;
        tick();
        flush      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'hF101_0000;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL fl3_half: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (inst_is32 !== 1'b1) $display("FAIL fl3_is32: got %b expected 1", inst_is32); else n_pass++;
        flush    = 1'b1;
        flush_pc = 32'h0000_0300;
        tick();
        flush      = 1'b0;
        word_valid = 1'b1;
        word_data  = 32'h4141_1888;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL fl3_inst: got %h expected 18880000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h300) $display("FAIL fl3_pc: got %h expected 300", inst_pc); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q[$];
        logic [31:0] words [4];
        int          widx;
        bit          e_ready;
        bit          e_valid;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            words[i] = {16'(16'h1000 + 2 * i + 1), 16'(16'h1000 + 2 * i)};
        end
        widx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            inst_ready = (cyc >= 4);
            word_valid = (widx < 4);
            word_data  = (widx < 4) ? words[widx] : 32'h0;
            @(negedge clk);
            e_ready = (exp_q.size() <= DEPTH - 2);
            e_valid = (exp_q.size() >= 1);
            n_checks++; if (word_ready !== e_ready) $display("FAIL bp_ready c%0d: got %b expected %b", cyc, word_ready, e_ready); else n_pass++;
            n_checks++; if (inst_valid !== e_valid) $display("FAIL bp_valid c%0d: got %b expected %b", cyc, inst_valid, e_valid); else n_pass++;
            if (e_valid) begin
                n_checks++; if (inst !== {exp_q[0], 16'h0}) $display("FAIL bp_inst c%0d: got %h expected %h", cyc, inst, {exp_q[0], 16'h0}); else n_pass++;
            end
            if (e_valid && inst_ready) void'(exp_q.pop_front());
            if (word_valid && e_ready) begin
                exp_q.push_back(words[widx][15:0]);
                exp_q.push_back(words[widx][31:16]);
                widx++;
            end
            tick();
        end
        n_checks++; if (widx != 4) $display("FAIL bp_all_accepted: got %0d expected 4", widx); else n_pass++;
        n_checks++; if (cnt16 !== exp_cnt(8)) $display("FAIL bp_cnt16: got %h expected %h", cnt16, exp_cnt(8)); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        word_valid = 1'b1;
        word_data  = 32'h4141_1888;
        tick();
        word_data = 32'h2222_3333;
        tick();
        word_valid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (inst_pc !== RST_PC) $display("FAIL ar_pc: got %h expected %h", inst_pc, RST_PC); else n_pass++;
        n_checks++; if (cnt16 !== 32'h0) $display("FAIL ar_cnt16: got %h expected 0", cnt16); else n_pass++;
        n_checks++; if (cnt32 !== 32'h0) $display("FAIL ar_cnt32: got %h expected 0", cnt32); else n_pass++;
        n_checks++; if (word_ready !== 1'b1) $display("FAIL ar_ready: got %b expected 1", word_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h4141_1888;
        tick();
        word_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst !== 32'h1888_0000) $display("FAIL ar_inst: got %h expected 18880000", inst); else n_pass++;
        n_checks++; if (inst_pc !== RST_PC) $display("FAIL ar_inst_pc: got %h expected %h", inst_pc, RST_PC); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] mq[$];
        logic [31:0] m_pc;
        bit          m_drop;
        int unsigned m_c16;
        int unsigned m_c32;
        logic [15:0] hw0;
        logic [15:0] hw1;
        int          sz;
        bit          h32;
        bit          e_ready;
        bit          e_valid;
        logic [31:0] e_inst;
        apply_reset();
        m_pc   = {RST_PC[31:1], 1'b0};
        m_drop = RST_PC[1];
        m_c16  = 0;
        m_c32  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            hw0 = 16'($urandom);
            hw1 = 16'($urandom);
            if ($urandom_range(0, 2) == 0) hw0[15:11] = 5'(5'b11101 + $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) hw1[15:11] = 5'(5'b11101 + $urandom_range(0, 2));
            word_valid = ($urandom_range(0, 9) < 6);
            word_data  = {hw1, hw0};
            flush      = ($urandom_range(0, 19) == 0);
            flush_pc   = $urandom;
            inst_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            sz      = mq.size();
            h32     = (sz >= 1) && ref_is32(mq[0]);
            e_ready = !flush && (sz <= DEPTH - 2);
            e_valid = !flush && ((sz >= 1 && !h32) || (sz >= 2 && h32));
            n_checks++; if (word_ready !== e_ready) $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, word_ready, e_ready); else n_pass++;
            n_checks++; if (inst_valid !== e_valid) $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, inst_valid, e_valid); else n_pass++;
            n_checks++; if (inst_pc !== m_pc) $display("FAIL rnd_pc c%0d: got %h expected %h", cyc, inst_pc, m_pc); else n_pass++;
            n_checks++; if (inst_is32 !== h32) $display("FAIL rnd_is32 c%0d: got %b expected %b", cyc, inst_is32, h32); else n_pass++;
            if (sz == 0 || e_valid) begin
                if (sz == 0) e_inst = 32'h0;
                else e_inst = h32 ? {mq[0], mq[1]} : {mq[0], 16'h0};
                n_checks++; if (inst !== e_inst) $display("FAIL rnd_inst c%0d: got %h expected %h", cyc, inst, e_inst); else n_pass++;
            end
            n_checks++; if (cnt16 !== exp_cnt(m_c16)) $display("FAIL rnd_cnt16 c%0d: got %h expected %h", cyc, cnt16, exp_cnt(m_c16)); else n_pass++;
            n_checks++; if (cnt32 !== exp_cnt(m_c32)) $display("FAIL rnd_cnt32 c%0d: got %h expected %h", cyc, cnt32, exp_cnt(m_c32)); else n_pass++;
            if (flush) begin
                mq.delete();
                m_pc   = {flush_pc[31:1], 1'b0};
                m_drop = flush_pc[1];
            end else begin
                if (e_valid && inst_ready) begin
                    void'(mq.pop_front());
                    if (h32) begin
                        void'(mq.pop_front());
                        m_pc = m_pc + 32'd4;
                        m_c32++;
                    end else begin
                        m_pc = m_pc + 32'd2;
                        m_c16++;
                    end
                end
                if (word_valid && e_ready) begin
                    if (!m_drop) mq.push_back(hw0);
                    mq.push_back(hw1);
                    m_drop = 1'b0;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single16();
        test_single32();
        test_straddle();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
